// File: rtl/display_pkg.sv
// Shared definitions for the three-digit BCD display: digit types,
// scan select states and active-low 7-segment patterns (g..a).
package display_pkg;

    localparam int NUM_DIGITS = 3;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        SEL_UNITS    = 2'd0,
        SEL_TENS     = 2'd1,
        SEL_HUNDREDS = 2'd2
    } sel_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder; non-BCD codes blank.
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Extends a single upstream decade count to three BCD digits by spotting the
// 9->0 units rollover, and scans the result onto a multiplexed 7-segment display.
module bcd_display_scanner
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  count,
    output logic [11:0] value,
    output logic        carry_out,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        err
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    bcd_t                  prevCount;
    logic                  rollover;
    logic [PRE_W-1:0]      prescaler;
    sel_t                  selState;
    sel_t                  selNext;
    bcd_t                  shownDigit;
    logic [6:0]            shownSeg;
    logic [NUM_DIGITS-1:0] anNext;

    // An invalid count can never equal 0, so it can never complete a rollover.
    assign rollover = (prevCount == 4'd9) && (count == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            value     <= 12'h000;
            prevCount <= 4'd0;
            carry_out <= 1'b0;
            err       <= 1'b0;
        end else begin
            value[3:0] <= count;
            prevCount  <= count;
            carry_out  <= 1'b0;
            if (count > 4'd9) begin
                err <= 1'b1;
            end
            if (rollover) begin
                if (value[7:4] == 4'd9) begin
                    value[7:4] <= 4'd0;
                    if (value[11:8] == 4'd9) begin
                        value[11:8] <= 4'd0;
                        carry_out   <= 1'b1;
                    end else begin
                        value[11:8] <= value[11:8] + 4'd1;
                    end
                end else begin
                    value[7:4] <= value[7:4] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            selState  <= SEL_UNITS;
        end else begin
            prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + 1'b1;
            selState  <= selNext;
        end
    end

    always_comb begin
        selNext = selState;
        if (prescaler == PRE_LAST) begin
            case (selState)
                SEL_UNITS:    selNext = SEL_TENS;
                SEL_TENS:     selNext = SEL_HUNDREDS;
                SEL_HUNDREDS: selNext = SEL_UNITS;
                default:      selNext = SEL_UNITS;
            endcase
        end
    end

    always_comb begin
        shownDigit = value[3:0];
        anNext     = 3'b110;
        case (selState)
            SEL_UNITS: begin
                shownDigit = value[3:0];
                anNext     = 3'b110;
            end
            SEL_TENS: begin
                shownDigit = value[7:4];
                anNext     = 3'b101;
            end
            SEL_HUNDREDS: begin
                shownDigit = value[11:8];
                anNext     = 3'b011;
            end
            default: begin
                shownDigit = value[3:0];
                anNext     = 3'b110;
            end
        endcase
    end

    bcd_to_7seg u_decode (
        .digit (shownDigit),
        .seg   (shownSeg)
    );

    // Registering the decoded digit means seg shows value as it stood last cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 3'b110;
            seg <= SEG_0;
        end else begin
            an  <= anNext;
            seg <= shownSeg;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner with SCAN_DIV=4: the driver queues
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_bcd_display_scanner;

    logic        clk;
    logic        reset;
    logic [3:0]  count;
    logic [11:0] value;
    logic        carry_out;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        err;

    typedef struct {
        int          due;
        string       name;
        logic [11:0] val;
        logic        carry;
        logic        err;
        logic        chkScan;
        logic [2:0]  an;
        logic [6:0]  seg;
    } exp_t;

    exp_t expQ[$];
    int   cycleCount = 0;
    int   checks     = 0;
    int   failures   = 0;

    bcd_display_scanner #(.SCAN_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .count     (count),
        .value     (value),
        .carry_out (carry_out),
        .seg       (seg),
        .an        (an),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    function automatic logic [11:0] toBcd(input int n);
        return {4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic checkOutput(input string name, input string field,
                               input logic [11:0] actual, input logic [11:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=%0h expected=%0h", name, field, actual, expected);
        end
    endtask

    // Monitor: compare every expectation whose due cycle has arrived.
    always @(negedge clk) begin
        while (expQ.size() > 0 && expQ[0].due <= cycleCount) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput(e.name, "value", value, e.val);
            checkOutput(e.name, "carry_out", {11'd0, carry_out}, {11'd0, e.carry});
            checkOutput(e.name, "err", {11'd0, err}, {11'd0, e.err});
            if (e.chkScan) begin
                checkOutput(e.name, "an", {9'd0, an}, {9'd0, e.an});
                checkOutput(e.name, "seg", {5'd0, seg}, {5'd0, e.seg});
            end
        end
    end

    task automatic applyStimulus(input string name, input logic rst, input logic [3:0] c,
                                 input logic [11:0] v, input logic cy, input logic e,
                                 input logic chkScan, input logic [2:0] a, input logic [6:0] s);
        exp_t x;
        @(posedge clk);
        #1;
        reset = rst;
        count = c;
        x.due     = cycleCount + 1;
        x.name    = name;
        x.val     = v;
        x.carry   = cy;
        x.err     = e;
        x.chkScan = chkScan;
        x.an      = a;
        x.seg     = s;
        expQ.push_back(x);
    endtask

    task automatic syncToUnits(input string name);
        logic [2:0] lastAn;
        bit         found;
        lastAn = an;
        found  = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (an == 3'b110 && lastAn != 3'b110) found = 1;
            lastAn = an;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL %s.sync actual=an_%b expected=an_110_edge", name, an);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        count = 4'd0;
        repeat (3) @(posedge clk);

        // Reset with prev preloaded at 9 and count 0 during reset
        applyStimulus("preload", 0, 4'd9, 12'h009, 0, 0, 0, 3'b000, 7'd0);
        applyStimulus("reset", 1, 4'd0, 12'h000, 0, 0, 1, 3'b110, 7'b1000000);
        applyStimulus("post_reset", 0, 4'd0, 12'h000, 0, 0, 0, 3'b000, 7'd0);

        // Single rollover
        applyStimulus("roll7", 0, 4'd7, 12'h007, 0, 0, 0, 3'b000, 7'd0);
        applyStimulus("roll8", 0, 4'd8, 12'h008, 0, 0, 0, 3'b000, 7'd0);
        applyStimulus("roll9", 0, 4'd9, 12'h009, 0, 0, 0, 3'b000, 7'd0);
        applyStimulus("roll0", 0, 4'd0, 12'h010, 0, 0, 0, 3'b000, 7'd0);

        // Clears that are not rollovers
        applyStimulus("clr5", 0, 4'd5, 12'h015, 0, 0, 0, 3'b000, 7'd0);
        applyStimulus("clr5to0", 0, 4'd0, 12'h010, 0, 0, 0, 3'b000, 7'd0);
        applyStimulus("clr3", 0, 4'd3, 12'h013, 0, 0, 0, 3'b000, 7'd0);
        applyStimulus("clr3to0", 0, 4'd0, 12'h010, 0, 0, 0, 3'b000, 7'd0);

        // Climb to 123
        for (int r = 0; r <= 10; r++) begin
            for (int u = 1; u <= 9; u++)
                applyStimulus("climb", 0, 4'(u), toBcd(10 * (1 + r) + u), 0, 0, 0, 3'b000, 7'd0);
            applyStimulus("climb_roll", 0, 4'd0, toBcd(10 * (2 + r)), 0, 0, 0, 3'b000, 7'd0);
        end
        applyStimulus("hold123", 0, 4'd3, 12'h123, 0, 0, 0, 3'b000, 7'd0);

        // Scan of 123
        syncToUnits("scan");
        for (int i = 0; i < 2; i++)
            applyStimulus("scan_u", 0, 4'd3, 12'h123, 0, 0, 1, 3'b110, 7'b0110000);
        for (int i = 0; i < 4; i++)
            applyStimulus("scan_t", 0, 4'd3, 12'h123, 0, 0, 1, 3'b101, 7'b0100100);
        for (int i = 0; i < 4; i++)
            applyStimulus("scan_h", 0, 4'd3, 12'h123, 0, 0, 1, 3'b011, 7'b1111001);
        for (int i = 0; i < 4; i++)
            applyStimulus("scan_u2", 0, 4'd3, 12'h123, 0, 0, 1, 3'b110, 7'b0110000);

        // Invalid input while units digit is on the display
        syncToUnits("invalid");
        applyStimulus("inv12", 0, 4'd12, 12'h12C, 0, 1, 1, 3'b110, 7'b0110000);
        applyStimulus("inv_then0", 0, 4'd0, 12'h120, 0, 1, 1, 3'b110, 7'b1111111);
        applyStimulus("inv_hold", 0, 4'd0, 12'h120, 0, 1, 1, 3'b101, 7'b0100100);
        applyStimulus("inv_sticky", 0, 4'd0, 12'h120, 0, 1, 0, 3'b000, 7'd0);

        // Full wrap 000 -> 999 -> 000
        applyStimulus("wrap_reset", 1, 4'd0, 12'h000, 0, 0, 1, 3'b110, 7'b1000000);
        applyStimulus("wrap_start", 0, 4'd0, 12'h000, 0, 0, 0, 3'b000, 7'd0);
        for (int k = 0; k < 100; k++) begin
            for (int u = 1; u <= 9; u++)
                applyStimulus("wrap", 0, 4'(u), toBcd((10 * k + u) % 1000), 0, 0, 0, 3'b000, 7'd0);
            applyStimulus("wrap_roll", 0, 4'd0, toBcd((10 * (k + 1)) % 1000), logic'(k == 99), 0, 0,
                          3'b000, 7'd0);
        end
        applyStimulus("wrap_after", 0, 4'd0, 12'h000, 0, 0, 0, 3'b000, 7'd0);

        repeat (3) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL leftover actual=%0d expected=0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
